// File: rtl/mem_pkg.sv
// Shared types and constants for the 16-bit RAM port master and its lane mux.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE
  } mem_state_e;

  localparam logic       LANE_LO     = 1'b0;
  localparam logic       LANE_HI     = 1'b1;
  localparam logic [1:0] MEM_BE_WORD = 2'b11;

  // Bits needed to index a RAM of the given depth.
  function automatic int word_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Byte-lane helper: extracts one lane of a RAM word (zero/sign-extended) and
// merges a store byte into a RAM word for read-modify-write.
module mem_lane_mux
  import mem_pkg::*;
(
  input  logic        lane_i,
  input  logic        sign_i,
  input  logic [15:0] word_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] load_o,
  output logic [15:0] merge_o
);

  logic [7:0] sel;

  always_comb begin
    sel     = (lane_i == LANE_LO) ? word_i[7:0] : word_i[15:8];
    load_o  = {{8{sign_i & sel[7]}}, sel};
    merge_o = (lane_i == LANE_HI) ? {byte_i, word_i[7:0]} : {word_i[15:8], byte_i};
  end

endmodule

// File: rtl/mem_port_master.sv
// CPU-side master for the 16-bit synchronous RAM. Byte stores become a
// read-modify-write so the RAM only ever sees full-word accesses.
module mem_port_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata
);

  localparam int                IDX_W     = word_idx_w(WORDS);
  localparam logic [ADDR_W-1:0] WORDS_LIM = ADDR_W'(WORDS);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, including the cycle resp_valid pulses.
  mem_state_e        state_q, state_d;
  logic              we_q, we_d, byte_q, byte_d, signed_q, signed_d, lane_q, lane_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d, err_q, err_d;

  logic [ADDR_W-2:0] req_idx;
  logic              out_of_range;
  logic [15:0]       load_data, merge_data;

  assign req_idx      = req_addr[ADDR_W-1:1];
  assign out_of_range = {1'b0, req_idx} >= WORDS_LIM;

  mem_lane_mux u_lane_mux (
    .lane_i  (lane_q),
    .sign_i  (signed_q),
    .word_i  (mem_rdata),
    .byte_i  (wbyte_q),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    byte_d       = byte_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wbyte_d      = wbyte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          byte_d   = req_byte;
          signed_d = req_signed;
          lane_d   = req_addr[0];
          wbyte_d  = req_wdata[7:0];
          if (out_of_range) begin
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else begin
            addr_d = ADDR_W'(req_idx[IDX_W-1:0]);
            if (req_we && !req_byte) begin
              wdata_d = req_wdata;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (we_q) begin
          wdata_d = merge_data;
          state_d = ST_WRITE;
        end else begin
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          rdata_d      = byte_q ? load_data : mem_rdata;
          state_d      = ST_IDLE;
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        err_d        = 1'b0;
        rdata_d      = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      lane_q       <= 1'b0;
      wbyte_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wbyte_q      <= wbyte_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Gating with reset keeps a reset that lands in WRITE from committing the write.
  assign mem_we     = (state_q == ST_WRITE) && !reset;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = MEM_BE_WORD;
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: directed cases plus random traffic, checked every
// cycle against a word-array reference model and expected-response queues.
module tb_mem_port_master;

  localparam int WORDS  = 256;
  localparam int ADDR_W = 16;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_be;
  logic        mem_we;

  mem_port_master #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- RAM attached to the DUT ----------------
  logic [15:0] ram [WORDS];
  logic [15:0] img [WORDS];
  logic        ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= img[i];
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[7:0]];
  end

  // ---------------- scoreboard state ----------------
  int          total, bad;
  logic [15:0] ref_mem [WORDS];
  int          rsp_due_q[$];
  logic [16:0] exp_q[$];       // {err, rdata}
  int          wr_due_q[$];
  logic [31:0] wr_q[$];        // {addr, data}
  logic [16:0] last_rsp;
  logic        chk_en;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", name, got, want, cyc);
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    logic ev, wv;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev = (rsp_due_q.size() > 0) && (rsp_due_q[0] == cyc);
        if (resp_valid || ev) begin
          chk("resp_valid", 32'(resp_valid), 32'(ev));
          if (resp_valid && ev) begin
            chk("resp_data", 32'({resp_err, resp_rdata}), 32'(exp_q[0]));
            last_rsp = exp_q[0];
          end
          if (ev) begin
            void'(rsp_due_q.pop_front());
            void'(exp_q.pop_front());
          end
        end else begin
          chk("resp_hold", 32'({resp_err, resp_rdata}), 32'(last_rsp));
        end
        wv = (wr_due_q.size() > 0) && (wr_due_q[0] == cyc);
        if (mem_we || wv) begin
          chk("mem_we", 32'(mem_we), 32'(wv));
          if (mem_we && wv) chk("mem_write", {mem_addr, mem_wdata}, wr_q[0]);
          if (wv) begin
            void'(wr_due_q.pop_front());
            void'(wr_q.pop_front());
          end
        end
        chk("mem_be", 32'(mem_be), 32'h3);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic we, input logic byt, input logic sgn,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] exp_rd, output int lat);
    int          idx, sh, acc, waited;
    logic [15:0] w, nw, mask;
    logic [7:0]  b;
    logic        err;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_wait", 32'(req_ready), 32'h1);
      exp_rd = '0;
      lat    = 0;
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_byte   = byt;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    idx    = int'(addr >> 1);
    sh     = addr[0] ? 8 : 0;
    acc    = cyc + 1;
    exp_rd = '0;
    err    = 1'b0;
    if (idx >= WORDS) begin
      err = 1'b1;
      lat = 1;
    end else if (!we) begin
      w = ref_mem[idx];
      if (byt) begin
        b      = 8'(w >> sh);
        exp_rd = sgn ? {{8{b[7]}}, b} : {8'h00, b};
      end else begin
        exp_rd = w;
      end
      lat = 3;
    end else begin
      if (byt) begin
        w    = ref_mem[idx];
        mask = 16'h00FF << sh;
        nw   = (w & ~mask) | ({8'h00, wdata[7:0]} << sh);
        lat  = 4;
      end else begin
        nw  = wdata;
        lat = 2;
      end
      ref_mem[idx] = nw;
      // the RAM write happens in the cycle just before the response
      wr_due_q.push_back(acc + lat - 2);
      wr_q.push_back({16'(idx), nw});
    end
    rsp_due_q.push_back(acc + lat - 1);
    exp_q.push_back({err, exp_rd});
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_byte   = 1'($urandom_range(0, 1));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_due_q.size() > 0 || wr_due_q.size() > 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(rsp_due_q.size() + wr_due_q.size()), 32'h0);
  endtask

  // Called just after a negedge sample: abandon the in-flight op and reset.
  task automatic abort_with_reset(input int idx, input logic [15:0] keep);
    rsp_due_q.delete();
    exp_q.delete();
    wr_due_q.delete();
    wr_q.delete();
    ref_mem[idx] = keep;
    last_rsp     = '0;
    reset        = 1'b1;
  endtask

  task automatic post_reset_checks(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'h0);
    chk({tag, "_maddr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] rd;
    int          lat;
    int          mism;
    reset      = 1'b1;
    ram_load   = 1'b1;
    chk_en     = 1'b0;
    last_rsp   = '0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_byte   = 1'b0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < WORDS; i++) begin
      img[i]     = 16'($urandom);
      ref_mem[i] = img[i];
    end
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rvalid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", 32'(resp_rdata), 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_mwdata", 32'(mem_wdata), 32'h0);
    ram_load = 1'b0;
    reset    = 1'b0;
    chk_en   = 1'b1;

    // word store then load
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, rd, lat);
    chk("lat_wstore", 32'(lat), 32'd2);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, lat);
    chk("lat_load", 32'(lat), 32'd3);
    chk("model_wload", 32'(rd), 32'hBEEF);
    drain();
    chk("ram8_beef", 32'(ram[8]), 32'hBEEF);

    // byte store, lane 1 then lane 0
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, rd, lat);
    issue(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00AB, rd, lat);
    chk("lat_bstore", 32'(lat), 32'd4);
    drain();
    chk("ram8_ab34", 32'(ram[8]), 32'hAB34);
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, rd, lat);
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'h00CD, rd, lat);
    drain();
    chk("ram8_12cd", 32'(ram[8]), 32'h12CD);

    // byte loads
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h80F0, rd, lat);
    issue(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, rd, lat);
    chk("model_bl_hi_u", 32'(rd), 32'h0080);
    issue(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, rd, lat);
    chk("model_bl_hi_s", 32'(rd), 32'hFF80);
    issue(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, rd, lat);
    chk("model_bl_lo_s", 32'(rd), 32'hFFF0);
    issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, rd, lat);
    chk("model_bl_lo_u", 32'(rd), 32'h00F0);

    // top in-range word, then out of range with a back-to-back follow-up
    issue(1'b1, 1'b0, 1'b0, 16'h01FE, 16'hC0DE, rd, lat);
    issue(1'b0, 1'b0, 1'b0, 16'h01FF, 16'h0000, rd, lat);
    chk("model_top_load", 32'(rd), 32'hC0DE);
    drain();
    issue(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, rd, lat);
    chk("lat_oor", 32'(lat), 32'd1);
    chk("oor_rvalid", 32'(resp_valid), 32'h1);
    chk("oor_ready", 32'(req_ready), 32'h1);
    chk("oor_err", 32'(resp_err), 32'h1);
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, lat);
    chk("model_b2b", 32'(rd), 32'h80F0);
    issue(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h5555, rd, lat);
    drain();

    // reset during CAPTURE of a byte store
    issue(1'b1, 1'b0, 1'b0, 16'h0020, 16'h5A5A, rd, lat);
    issue(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0077, rd, lat);
    @(negedge clk);
    #2 abort_with_reset(16, 16'h5A5A);
    @(negedge clk);
    reset = 1'b0;
    post_reset_checks("rstcap");
    @(negedge clk);
    chk("rstcap_ram", 32'(ram[16]), 32'h5A5A);

    // reset during WRITE of a byte store
    issue(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0011, rd, lat);
    @(negedge clk);
    @(negedge clk);
    #2 abort_with_reset(16, 16'h5A5A);
    #1 chk("rstwr_we_gated", 32'(mem_we), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    post_reset_checks("rstwr");
    @(negedge clk);
    chk("rstwr_ram", 32'(ram[16]), 32'h5A5A);

    // random traffic
    for (int n = 0; n < 250; n++) begin
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(512, 65535));
      else a = 16'($urandom_range(0, 511));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            a, 16'($urandom), rd, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    mism = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_final", 32'(mism), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator side of the 16-bit synchronous RAM port: accepts CPU load/store requests and drives the RAM's address, write-data, byte-enable and write-enable inputs.
- The RAM returns read data one clock after the address is presented.
- Byte stores are done as read-modify-write inside this block, so the RAM only ever sees full-word accesses.
- Sits between the CPU execute stage and the RAM.

Parameters:
- ADDR_W, 16, width of the CPU byte address and of mem_addr.
- WORDS, 256, RAM depth in 16-bit words; word indices >= WORDS are out of range.

Ports:
- clk  in  1  single system clock, all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:1], lane = req_addr[0]
- req_wdata  in  16  store data; byte store uses [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  16  load result, valid with resp_valid
- resp_err  out  1  out-of-range access, valid with resp_valid
- mem_addr  out  16  RAM word index
- mem_wdata  out  16  RAM write data
- mem_be  out  2  RAM byte enable, constant 2'b11
- mem_we  out  1  RAM write enable
- mem_rdata  in  16  RAM read data, valid the cycle after the address is held

Behaviour:
- Lane mapping: lane 0 = bits [7:0], lane 1 = bits [15:8]. Word accesses ignore req_addr[0].
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_addr 0, mem_wdata 0.
- mem_we is gated combinationally by !reset, so asserting reset in any state, including WRITE, never produces a RAM write on that edge.
- Reset mid-operation drops the request with no response.
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request.
  - Out-of-range index: go to IDLE, resp_valid = 1, resp_err = 1, resp_rdata = 0, no RAM access.
  - Word store: go to WRITE with wbuf = req_wdata.
  - Load or byte store: go to READ.
- READ: mem_addr = latched index, mem_we = 0; go to CAPTURE.
- CAPTURE: mem_rdata is valid this cycle.
  - Word load: resp_rdata = mem_rdata.
  - Byte load: resp_rdata = selected lane, zero- or sign-extended; then resp_valid and go to IDLE.
  - Byte store: wbuf = mem_rdata with the selected lane replaced by req_wdata[7:0], other lane preserved; go to WRITE.
- WRITE: mem_addr = index, mem_wdata = wbuf, mem_we = 1; go to IDLE with resp_valid = 1, resp_rdata = 0.
- req_ready is 1 only in IDLE. A new request may be accepted in the same cycle resp_valid is high (back-to-back).
- Latency (accept edge to resp_valid high):
  - word store 2 cycles
  - load 3 cycles
  - byte store 4 cycles
  - out-of-range 1 cycle
- resp_valid is always exactly one cycle wide. resp_rdata and resp_err hold until the next response.
- The latched request is stable for the whole operation; req_* changes after acceptance are ignored.
- mem_addr holds its value in IDLE; it is never X after reset.

Decomposition:
- Shared package mem_pkg holds:
  - state enum (IDLE, READ, CAPTURE, WRITE)
  - lane constants LANE_LO = 0, LANE_HI = 1
  - MEM_BE_WORD = 2'b11
  - word-index width derived from WORDS
- One combinational sub-module, mem_lane_mux, does lane extract with zero/sign-extend and lane merge for byte stores.
- The FSM, request latch and response registers stay in mem_port_master.

Test Plan:
- Word store then load: store addr 0x0010 data 0xBEEF, then load 0x0010 -> mem_we high one cycle with mem_addr 0x0008; load resp_rdata 0xBEEF, resp_err 0; latencies 2 and 3.
- Byte store lane 1: RAM[8] = 0x1234; store byte addr 0x0011 data 0x00AB -> RAM[8] = 0xAB34, resp after 4 cycles.
- Byte store lane 0: RAM[8] = 0x1234; store byte addr 0x0010 data 0x00CD -> RAM[8] = 0x12CD.
- Byte loads from RAM[8] = 0x80F0:
  - addr 0x0011, unsigned -> 0x0080
  - addr 0x0011, signed -> 0xFF80
  - addr 0x0010, signed -> 0xFFF0
- Out of range: load addr 0x0200 (index 256) -> resp_valid next cycle, resp_err 1, rdata 0, mem_we never asserted; then a back-to-back valid request is accepted on the resp_valid cycle.
- Reset mid byte store: assert reset during CAPTURE and again during WRITE -> no mem_we edge, RAM word unchanged, no resp_valid; req_ready = 1 the cycle after reset deasserts.
